// File: rtl/mat_pkg.sv
// Shared types and constants for the matrix tile scheduler: sizes, one-hot
// FSM encoding, the per-tile command bundle and the edge-tile size helper.
package mat_pkg;
    localparam int TILE  = 8;
    localparam int DIM_W = 8;
    localparam int CNT_W = 16;

    localparam logic [DIM_W-1:0] TILE_D = DIM_W'(TILE);
    localparam logic [DIM_W:0]   TILE_X = (DIM_W+1)'(TILE);

    typedef enum logic [5:0] {
        S_IDLE       = 6'b000001,
        S_ISSUE      = 6'b000010,
        S_WAIT_CALC  = 6'b000100,
        S_WAIT_DRAIN = 6'b001000,
        S_NEXT       = 6'b010000,
        S_FINISH     = 6'b100000
    } state_e;

    typedef struct packed {
        logic [DIM_W-1:0] row_base;
        logic [DIM_W-1:0] col_base;
        logic [7:0]       sub_M;
        logic [7:0]       sub_N;
        logic [7:0]       sub_P;
    } tile_cmd_t;

    // Edge tiles are clipped to whatever remains of the matrix dimension.
    function automatic logic [7:0] min_tile(input logic [DIM_W-1:0] dim,
                                            input logic [DIM_W-1:0] base);
        logic [DIM_W-1:0] rem;
        rem = dim - base;
        return (rem >= TILE_D) ? 8'(TILE_D) : 8'(rem);
    endfunction
endpackage

// File: rtl/tile_drain_counter.sv
// Counts results leaving the array for the current tile, flags completion and
// keeps a sticky error for stray or surplus results.
module tile_drain_counter
    import mat_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] expected_i,
    input  logic             cnt_en_i,
    input  logic             out_valid_i,
    input  logic             stray_i,
    input  logic             err_clr_i,
    output logic             reached_o,
    output logic             err_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d, exp_q;
    logic             err_q, hit;

    assign hit       = cnt_en_i && out_valid_i;
    assign cnt_d     = cnt_q + CNT_W'(hit);
    // Includes the result arriving this cycle so the FSM can leave without a bubble.
    assign reached_o = (cnt_d == exp_q);
    assign err_o     = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            exp_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (clr_i)       cnt_q <= '0;
            else if (hit)    cnt_q <= cnt_d;
            if (load_i)      exp_q <= expected_i;
            if (err_clr_i)   err_q <= 1'b0;
            else if (stray_i || (hit && cnt_q >= exp_q)) err_q <= 1'b1;
        end
    end
endmodule

// File: rtl/mat_tile_scheduler.sv
// Walks C = A*B in raster order of TILE x TILE output tiles, handing each tile
// to the multiply controller and waiting for its results to drain.
module mat_tile_scheduler
    import mat_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DIM_W-1:0] cfg_M,
    input  logic [DIM_W-1:0] cfg_N,
    input  logic [DIM_W-1:0] cfg_P,
    output logic             busy,
    output logic             done,
    output logic             tile_valid,
    input  logic             tile_ready,
    output logic [DIM_W-1:0] tile_row_base,
    output logic [DIM_W-1:0] tile_col_base,
    output logic [7:0]       sub_scale_M,
    output logic [7:0]       sub_scale_N,
    output logic [7:0]       sub_scale_P,
    input  logic             align_get_all,
    input  logic             out_valid,
    output logic             drain_err
);
    state_e           state_q;
    tile_cmd_t        cmd_q;
    logic [DIM_W-1:0] m_q, p_q, row_d, col_d;
    logic [DIM_W:0]   csum, rsum;
    logic             busy_q, done_q, tile_valid_q, ga_prev_q;
    logic             col_wrap, last_tile, start_acc, accept, reached;

    assign busy          = busy_q;
    assign done          = done_q;
    assign tile_valid    = tile_valid_q;
    assign tile_row_base = cmd_q.row_base;
    assign tile_col_base = cmd_q.col_base;
    assign sub_scale_M   = cmd_q.sub_M;
    assign sub_scale_N   = cmd_q.sub_N;
    assign sub_scale_P   = cmd_q.sub_P;

    assign start_acc = (state_q == S_IDLE) && start;
    assign accept    = (state_q == S_ISSUE) && tile_valid_q && tile_ready;

    // One extra bit on the sums keeps dimensions near 255 from wrapping.
    always_comb begin
        csum      = {1'b0, cmd_q.col_base} + TILE_X;
        rsum      = {1'b0, cmd_q.row_base} + TILE_X;
        col_wrap  = (csum >= {1'b0, p_q});
        last_tile = col_wrap && (rsum >= {1'b0, m_q});
        col_d     = col_wrap ? '0 : csum[DIM_W-1:0];
        row_d     = col_wrap ? rsum[DIM_W-1:0] : cmd_q.row_base;
    end

    tile_drain_counter u_drain (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (start_acc || (state_q == S_NEXT)),
        .load_i      (accept),
        .expected_i  (CNT_W'(cmd_q.sub_M) * CNT_W'(cmd_q.sub_P)),
        .cnt_en_i    ((state_q == S_WAIT_CALC) || (state_q == S_WAIT_DRAIN)),
        .out_valid_i (out_valid),
        .stray_i     (out_valid && ((state_q == S_IDLE) || (state_q == S_ISSUE) ||
                                    (state_q == S_NEXT))),
        .err_clr_i   (start_acc),
        .reached_o   (reached),
        .err_o       (drain_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cmd_q        <= '0;
            m_q          <= '0;
            p_q          <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            tile_valid_q <= 1'b0;
            ga_prev_q    <= 1'b0;
        end else begin
            ga_prev_q <= align_get_all;
            done_q    <= 1'b0;
            unique case (state_q)
                S_IDLE: if (start) begin
                    m_q    <= cfg_M;
                    p_q    <= cfg_P;
                    busy_q <= 1'b1;
                    if (cfg_M == '0 || cfg_P == '0) begin
                        state_q <= S_FINISH;
                    end else begin
                        cmd_q        <= '{row_base: '0, col_base: '0,
                                          sub_M: min_tile(cfg_M, '0), sub_N: cfg_N,
                                          sub_P: min_tile(cfg_P, '0)};
                        tile_valid_q <= 1'b1;
                        state_q      <= S_ISSUE;
                    end
                end
                S_ISSUE: if (tile_ready) begin
                    tile_valid_q <= 1'b0;
                    state_q      <= S_WAIT_CALC;
                end
                // Only a fresh rising edge of get-all counts for this tile.
                S_WAIT_CALC: if (align_get_all && !ga_prev_q) state_q <= S_WAIT_DRAIN;
                S_WAIT_DRAIN: if (reached) state_q <= S_NEXT;
                S_NEXT: if (last_tile) begin
                    cmd_q   <= '0;
                    state_q <= S_FINISH;
                end else begin
                    cmd_q.row_base <= row_d;
                    cmd_q.col_base <= col_d;
                    cmd_q.sub_M    <= min_tile(m_q, row_d);
                    cmd_q.sub_P    <= min_tile(p_q, col_d);
                    tile_valid_q   <= 1'b1;
                    state_q        <= S_ISSUE;
                end
                S_FINISH: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    cmd_q   <= '0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule
